if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage sitting directly downstream of the pre-IF stage. It tracks the single in-flight instruction-cache read that pre-IF issued, captures the returned instruction word, and holds it until decode accepts it. It also discards responses orphaned by a pipeline flush and reports slot occupancy back to pre-IF for delay-slot tracking.

## Interface
Parameters: none; widths come from `mycpu.h`.
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- to_fs_valid  in  1  pre-IF request accepted by the cache this cycle
- preif_to_fs_bus  in  `PF_TO_FS_BUS_WD` (71)  fields, MSB first:
  - tlb_refill [70]
  - badvaddr [69:38]
  - has_ex [37]
  - ex_type [36:32]
  - pc [31:0]
- fs_allowin  out  1  this stage can accept `to_fs_valid` this cycle
- fs_has_inst  out  1  slot holds a live (non-discarded) instruction
- inst_cache_data_ok  in  1  read data returned this cycle; in-order, one per accepted request
- inst_cache_rdata  in  32  instruction word, valid with `data_ok`
- fs_flush  in  1  exception, cancel or eret; same cycle pre-IF reflushes
- ds_allowin  in  1  decode accepts this cycle
- fs_to_ds_valid  out  1  instruction offered to decode
- fs_to_ds_bus  out  `FS_TO_DS_BUS_WD` (103)  fields, MSB first:
  - tlb_refill [102]
  - badvaddr [101:70]
  - has_ex [69]
  - ex_type [68:64]
  - inst [63:32]
  - pc [31:0]

## Operation
- State register, 2 bits:
  - EMPTY=0
  - WAIT=1: request outstanding
  - READY=2: instruction buffered
  - DISCARD=3: outstanding response must be dropped
- Accepting a request (`to_fs_valid & fs_allowin`) latches `preif_to_fs_bus` into the slot registers and moves to WAIT.
- `fs_to_ds_valid = ~fs_flush & (READY | (WAIT & data_ok))`.
- `inst` field mux: `inst_cache_rdata` in WAIT, buffered word in READY.
- `fs_allowin` is asserted in these cases and deasserted otherwise:
  - EMPTY
  - READY & (ds_allowin | fs_flush)
  - WAIT & data_ok & (ds_allowin | fs_flush)
  - DISCARD & data_ok
- `fs_has_inst = WAIT | READY`.
- Transitions, with `acc = to_fs_valid & fs_allowin`. Each state goes to WAIT on `acc`; otherwise:
  - EMPTY: stay EMPTY.
  - WAIT, data_ok:
    - no flush and ~ds_allowin: capture rdata, go to READY.
    - flush or ds_allowin: go to EMPTY.
  - WAIT, no data_ok:
    - flush: go to DISCARD.
    - else: stay in WAIT.
  - READY:
    - flush or ds_allowin: go to EMPTY.
    - else: stay in READY.
  - DISCARD:
    - data_ok: go to EMPTY; the word is dropped.
    - else: stay in DISCARD.
- `fs_flush` never blocks a same-cycle new request. That request carries the reflush PC and is kept.
- Exception-tagged requests (`has_ex`=1) still wait for `data_ok`, because the cache request was issued. `inst` is forwarded unchanged; decode ignores it.
- `data_ok` in EMPTY or READY is a protocol violation. The design ignores it; the bench asserts it never occurs.

## Timing
- Reset values:
  - state EMPTY
  - all slot registers 0
  - fs_to_ds_valid 0
  - fs_has_inst 0
  - fs_allowin 1 (pre-IF gates its request with reset)
- Latency: `data_ok` at the earliest 1 cycle after acceptance. On `data_ok` with `ds_allowin`=1, the instruction passes combinationally to decode in that same cycle.
- Throughput: one instruction per cycle when the cache returns back-to-back and decode never stalls.
- Slot and buffer registers update only on the clock edge. Reset asserted mid-WAIT returns to EMPTY; any late `data_ok` is then ignored.
- Flush in READY or in WAIT with `data_ok`: `fs_to_ds_valid` is 0 in that cycle, so nothing leaks to decode.

## Structure
- In `mycpu.h`:
  - `FS_TO_DS_BUS_WD` (103), beside the existing `PF_TO_FS_BUS_WD`
  - FS state encodings as defines
- Single flat module, no sub-module; the slot is one register bank plus a 32-bit inst buffer.

## Test plan
- Straight fetch: accept pc=0xbfc00000; `data_ok` 1 cycle later with rdata=0x24010001 and `ds_allowin`=1. Decode sees `{pc, inst}` in that cycle, and `fs_allowin`=1 in the same cycle.
- Decode stall: `data_ok` with `ds_allowin`=0 → READY, inst buffered. Hold 3 cycles: bus stable, `fs_allowin`=0. Raise `ds_allowin` → handoff, then EMPTY.
- Flush while waiting: WAIT, assert `fs_flush` without `data_ok` → DISCARD, `fs_has_inst`=0. Next `data_ok` (rdata=0xdeadbeef) is not forwarded. A same-cycle accept of pc=0xbfc00380 → WAIT.
- Flush with buffered inst: READY plus `fs_flush` and `to_fs_valid` (pc=0xbfc00380) → `fs_to_ds_valid`=0 that cycle, new request in WAIT.
- Exception passthrough: accept with `has_ex`=1, ex_type=0x4, badvaddr=0xbfc00001. After `data_ok`, decode bus carries those fields unchanged.
- Async reset: assert reset in WAIT mid-cycle → outputs reach their reset values before the next edge; a post-reset `data_ok` is ignored.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: bus widths and slot state encoding shared by the fetch stage and its bench
package if_stage_pkg;
  localparam int PF_TO_FS_BUS_WD = 71;
  localparam int FS_TO_DS_BUS_WD = 103;
  typedef enum logic [1:0] {
    FS_EMPTY   = 2'd0,
    FS_WAIT    = 2'd1,
    FS_READY   = 2'd2,
    FS_DISCARD = 2'd3
  } fs_state_e;
endpackage

// File: rtl/if_stage.sv
// if_stage: tracks the single in-flight icache read from pre-IF, buffers the word until decode takes it
//   clk, reset          clock, async active-high reset
//   to_fs_valid         pre-IF request accepted by the cache this cycle
//   preif_to_fs_bus     {tlb_refill, badvaddr, has_ex, ex_type, pc}
//   fs_allowin          slot can take a request this cycle
//   fs_has_inst         slot holds a live instruction (outstanding or buffered)
//   inst_cache_*        in-order read response
//   fs_flush            pipeline flush; orphans any outstanding response
//   ds_allowin          decode accepts this cycle
//   fs_to_ds_valid/bus  {tlb_refill, badvaddr, has_ex, ex_type, inst, pc}
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       to_fs_valid,
  input  logic [PF_TO_FS_BUS_WD-1:0] preif_to_fs_bus,
  output logic                       fs_allowin,
  output logic                       fs_has_inst,
  input  logic                       inst_cache_data_ok,
  input  logic [31:0]                inst_cache_rdata,
  input  logic                       fs_flush,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);
  fs_state_e                  state_q, state_d, hold_d;
  logic [PF_TO_FS_BUS_WD-1:0] slot_q, slot_d;
  logic [31:0]                inst_q, inst_d;
  logic                       acc, leave, is_wait, is_ready;
  logic [31:0]                inst;

  assign is_wait  = state_q == FS_WAIT;
  assign is_ready = state_q == FS_READY;
  // a held or arriving word leaves the slot when decode takes it or a flush kills it
  assign leave    = ds_allowin | fs_flush;

  assign fs_allowin = (state_q == FS_EMPTY)
                    | (is_ready & leave)
                    | (is_wait & inst_cache_data_ok & leave)
                    | ((state_q == FS_DISCARD) & inst_cache_data_ok);
  assign acc         = to_fs_valid & fs_allowin;
  assign fs_has_inst = is_wait | is_ready;

  assign fs_to_ds_valid = ~fs_flush & (is_ready | (is_wait & inst_cache_data_ok));
  assign inst           = is_wait ? inst_cache_rdata : inst_q;
  assign fs_to_ds_bus   = {slot_q[70:32], inst, slot_q[31:0]};

  always_comb begin
    hold_d = state_q;
    case (state_q)
      FS_WAIT:    hold_d = inst_cache_data_ok ? (leave ? FS_EMPTY : FS_READY)
                                              : (fs_flush ? FS_DISCARD : FS_WAIT);
      FS_READY:   hold_d = leave ? FS_EMPTY : FS_READY;
      FS_DISCARD: hold_d = inst_cache_data_ok ? FS_EMPTY : FS_DISCARD;
      default:    hold_d = FS_EMPTY;
    endcase
    // a same-cycle request after a flush carries the reflush PC and must be kept
    state_d = acc ? FS_WAIT : hold_d;
    slot_d  = acc ? preif_to_fs_bus : slot_q;
    inst_d  = (is_wait & inst_cache_data_ok & ~leave) ? inst_cache_rdata : inst_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_EMPTY;
      slot_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      inst_q  <= inst_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for the fetch stage
module tb_if_stage;
  import if_stage_pkg::*;
  logic                       clk = 0;
  logic                       reset = 1;
  logic                       to_fs_valid = 0;
  logic [PF_TO_FS_BUS_WD-1:0] preif_to_fs_bus = '0;
  logic                       fs_allowin, fs_has_inst, fs_to_ds_valid;
  logic                       inst_cache_data_ok = 0;
  logic [31:0]                inst_cache_rdata = '0;
  logic                       fs_flush = 0;
  logic                       ds_allowin = 1;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  int                         total = 0;
  int                         bad = 0;
  logic                       proto_chk = 1;

  if_stage dut (
    .clk(clk), .reset(reset), .to_fs_valid(to_fs_valid), .preif_to_fs_bus(preif_to_fs_bus),
    .fs_allowin(fs_allowin), .fs_has_inst(fs_has_inst), .inst_cache_data_ok(inst_cache_data_ok),
    .inst_cache_rdata(inst_cache_rdata), .fs_flush(fs_flush), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (proto_chk && !reset && inst_cache_data_ok &&
        !(dut.state_q == FS_WAIT || dut.state_q == FS_DISCARD)) begin
      bad++;
      $display("FAIL proto: data_ok in state %0d", dut.state_q);
    end

  function automatic logic [PF_TO_FS_BUS_WD-1:0] pf(logic r, logic [31:0] bv, logic ex, logic [4:0] et, logic [31:0] pc);
    return {r, bv, ex, et, pc};
  endfunction

  function automatic logic [FS_TO_DS_BUS_WD-1:0] ds(logic r, logic [31:0] bv, logic ex, logic [4:0] et, logic [31:0] in, logic [31:0] pc);
    return {r, bv, ex, et, in, pc};
  endfunction

  task automatic step();
    @(negedge clk);
    to_fs_valid = 0; inst_cache_data_ok = 0; fs_flush = 0; ds_allowin = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got %b want 1", fs_allowin); end
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL reset_has_inst got %b want 0", fs_has_inst); end
    if (fs_to_ds_bus !== '0) begin bad++; $display("FAIL reset_bus got %h want 0", fs_to_ds_bus); end
    reset = 0;
  endtask

  task automatic test_straight();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00000); #1;
    total++;
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL straight_acc got %b want 1", fs_allowin); end
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h24010001; #1;
    total += 4;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL straight_valid got %b want 1", fs_to_ds_valid); end
    if (fs_to_ds_bus !== ds(0, 0, 0, 0, 32'h24010001, 32'hbfc00000)) begin bad++; $display("FAIL straight_bus got %h", fs_to_ds_bus); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL straight_allowin got %b want 1", fs_allowin); end
    if (fs_has_inst !== 1'b1) begin bad++; $display("FAIL straight_has got %b want 1", fs_has_inst); end
    step(); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL straight_after_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL straight_after_has got %b want 0", fs_has_inst); end
  endtask

  task automatic test_stall();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00004);
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h8c220000; ds_allowin = 0; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL stall_dok_valid got %b want 1", fs_to_ds_valid); end
    if (fs_allowin !== 1'b0) begin bad++; $display("FAIL stall_dok_allowin got %b want 0", fs_allowin); end
    for (int i = 0; i < 3; i++) begin
      step(); ds_allowin = 0; inst_cache_rdata = 32'h0badf00d; #1;
      total += 3;
      if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid[%0d] got %b want 1", i, fs_to_ds_valid); end
      if (fs_allowin !== 1'b0) begin bad++; $display("FAIL stall_hold_allowin[%0d] got %b want 0", i, fs_allowin); end
      if (fs_to_ds_bus !== ds(0, 0, 0, 0, 32'h8c220000, 32'hbfc00004)) begin bad++; $display("FAIL stall_hold_bus[%0d] got %h", i, fs_to_ds_bus); end
    end
    step(); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL stall_release_valid got %b want 1", fs_to_ds_valid); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL stall_release_allowin got %b want 1", fs_allowin); end
    step(); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL stall_empty_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL stall_empty_has got %b want 0", fs_has_inst); end
  endtask

  task automatic test_flush_wait();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00008);
    step(); fs_flush = 1; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fw_flush_valid got %b want 0", fs_to_ds_valid); end
    if (fs_allowin !== 1'b0) begin bad++; $display("FAIL fw_flush_allowin got %b want 0", fs_allowin); end
    step(); #1;
    total += 3;
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL fw_discard_has got %b want 0", fs_has_inst); end
    if (fs_allowin !== 1'b0) begin bad++; $display("FAIL fw_discard_allowin got %b want 0", fs_allowin); end
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fw_discard_valid got %b want 0", fs_to_ds_valid); end
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'hdeadbeef;
    to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00380); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fw_drop_valid got %b want 0", fs_to_ds_valid); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL fw_drop_allowin got %b want 1", fs_allowin); end
    step(); #1;
    total += 3;
    if (fs_has_inst !== 1'b1) begin bad++; $display("FAIL fw_new_has got %b want 1", fs_has_inst); end
    if (fs_allowin !== 1'b0) begin bad++; $display("FAIL fw_new_allowin got %b want 0", fs_allowin); end
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fw_new_valid got %b want 0", fs_to_ds_valid); end
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h3c1a0000; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL fw_deliver_valid got %b want 1", fs_to_ds_valid); end
    if (fs_to_ds_bus !== ds(0, 0, 0, 0, 32'h3c1a0000, 32'hbfc00380)) begin bad++; $display("FAIL fw_deliver_bus got %h", fs_to_ds_bus); end
  endtask

  task automatic test_flush_ready();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc0000c);
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h11111111; ds_allowin = 0;
    step(); ds_allowin = 0; fs_flush = 1; to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00380); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fr_flush_valid got %b want 0", fs_to_ds_valid); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL fr_flush_allowin got %b want 1", fs_allowin); end
    step(); #1;
    total += 2;
    if (fs_has_inst !== 1'b1) begin bad++; $display("FAIL fr_wait_has got %b want 1", fs_has_inst); end
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fr_wait_valid got %b want 0", fs_to_ds_valid); end
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h12345678; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL fr_deliver_valid got %b want 1", fs_to_ds_valid); end
    if (fs_to_ds_bus !== ds(0, 0, 0, 0, 32'h12345678, 32'hbfc00380)) begin bad++; $display("FAIL fr_deliver_bus got %h", fs_to_ds_bus); end
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, 32'hbfc00010);
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h22222222; fs_flush = 1; ds_allowin = 0; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL fr_waitdok_valid got %b want 0", fs_to_ds_valid); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL fr_waitdok_allowin got %b want 1", fs_allowin); end
    step(); #1;
    total++;
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL fr_waitdok_has got %b want 0", fs_has_inst); end
  endtask

  task automatic test_exception();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 32'hbfc00001, 1, 5'h4, 32'hbfc00001);
    step(); #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL exc_wait_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b1) begin bad++; $display("FAIL exc_wait_has got %b want 1", fs_has_inst); end
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'hffffffff; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL exc_valid got %b want 1", fs_to_ds_valid); end
    if (fs_to_ds_bus !== ds(0, 32'hbfc00001, 1, 5'h4, 32'hffffffff, 32'hbfc00001)) begin bad++; $display("FAIL exc_bus got %h", fs_to_ds_bus); end
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(1, 32'h00400000, 1, 5'h2, 32'h00400000);
    step(); inst_cache_data_ok = 1; inst_cache_rdata = 32'h00000000; #1;
    total++;
    if (fs_to_ds_bus !== ds(1, 32'h00400000, 1, 5'h2, 32'h0, 32'h00400000)) begin bad++; $display("FAIL exc_refill_bus got %h", fs_to_ds_bus); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5] = '{32'hbfc00100, 32'hbfc00104, 32'hbfc00108, 32'hbfc0010c, 32'hbfc00110};
    logic [31:0] ins [5] = '{32'ha0000001, 32'hb0000002, 32'hc0000003, 32'hd0000004, 32'he0000005};
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, pcs[0]);
    for (int i = 0; i < 5; i++) begin
      step(); inst_cache_data_ok = 1; inst_cache_rdata = ins[i];
      if (i < 4) begin to_fs_valid = 1; preif_to_fs_bus = pf(0, 0, 0, 0, pcs[i+1]); end
      #1;
      total += 3;
      if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, fs_to_ds_valid); end
      if (fs_allowin !== 1'b1) begin bad++; $display("FAIL b2b_allowin[%0d] got %b want 1", i, fs_allowin); end
      if (fs_to_ds_bus !== ds(0, 0, 0, 0, ins[i], pcs[i])) begin bad++; $display("FAIL b2b_bus[%0d] got %h", i, fs_to_ds_bus); end
    end
    step(); #1;
    total++;
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL b2b_end_has got %b want 0", fs_has_inst); end
  endtask

  task automatic test_async_reset();
    step(); to_fs_valid = 1; preif_to_fs_bus = pf(1, 32'h12345678, 1, 5'h7, 32'hbfc00200);
    step(); #1;
    total++;
    if (fs_has_inst !== 1'b1) begin bad++; $display("FAIL ar_wait_has got %b want 1", fs_has_inst); end
    #2 reset = 1;
    #1;
    total += 4;
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL ar_has got %b want 0", fs_has_inst); end
    if (fs_allowin !== 1'b1) begin bad++; $display("FAIL ar_allowin got %b want 1", fs_allowin); end
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got %b want 0", fs_to_ds_valid); end
    if (fs_to_ds_bus !== '0) begin bad++; $display("FAIL ar_bus got %h want 0", fs_to_ds_bus); end
    step(); reset = 0; proto_chk = 0; inst_cache_data_ok = 1; inst_cache_rdata = 32'hcafef00d; #1;
    total += 2;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL ar_late_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL ar_late_has got %b want 0", fs_has_inst); end
    step(); proto_chk = 1; #1;
    total += 3;
    if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL ar_after_valid got %b want 0", fs_to_ds_valid); end
    if (fs_has_inst !== 1'b0) begin bad++; $display("FAIL ar_after_has got %b want 0", fs_has_inst); end
    if (fs_to_ds_bus !== '0) begin bad++; $display("FAIL ar_after_bus got %h want 0", fs_to_ds_bus); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_flush_wait();
    test_flush_ready();
    test_exception();
    test_back_to_back();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
